// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipe_pkg;
    localparam int STAGE_NUM = 6;

    localparam int PC_STAGE  = 0;
    localparam int IF_STAGE  = 1;
    localparam int ID_STAGE  = 2;
    localparam int EX_STAGE  = 3;
    localparam int MEM_STAGE = 4;
    localparam int WB_STAGE  = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } pctrl_state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/decision bundle between the pipeline stages and the stall/flush controller.
interface pipe_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic                 if_busy;
    logic                 id_hazard;
    logic                 ex_busy;
    logic                 mem_busy;
    logic                 branch_taken;
    logic [31:0]          branch_target;
    logic [STAGE_NUM-1:0] stall;
    logic                 flush;
    logic                 pc_redirect;
    logic [31:0]          redirect_pc;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output if_busy, id_hazard, ex_busy, mem_busy, branch_taken, branch_target,
        input  stall, flush, pc_redirect, redirect_pc, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_busy, id_hazard, ex_busy, mem_busy, branch_taken, branch_target,
        output stall, flush, pc_redirect, redirect_pc, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/pipe_ctrl.sv
// Merges stage stall requests, turns EX branch decisions into flush + PC redirect,
// and defers the redirect until an outstanding instruction fetch has drained.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    logic [STAGE_NUM-1:0] req;
    logic [STAGE_NUM-1:0] stall_raw;
    pctrl_state_e         state_reg, state_next;
    logic [31:0]          tgt_reg, tgt_next;
    logic                 flush_next;
    logic                 redirect_next;
    logic [31:0]          pc_next;
    logic                 accept;

    assign req[PC_STAGE]  = 1'b0;
    assign req[IF_STAGE]  = bus.if_busy;
    assign req[ID_STAGE]  = bus.id_hazard;
    assign req[EX_STAGE]  = bus.ex_busy;
    assign req[MEM_STAGE] = bus.mem_busy;
    assign req[WB_STAGE]  = 1'b0;

    // A stage stops when it or any later stage requests a stall.
    generate
        for (genvar gi = 0; gi < STAGE_NUM; gi++) begin : g_merge
            assign stall_raw[gi] = |req[STAGE_NUM-1:gi] ? STOP : NO_STOP;
        end
    endgenerate

    assign accept = bus.branch_taken && (stall_raw[EX_STAGE] == NO_STOP);

    always_comb begin
        state_next    = state_reg;
        tgt_next      = tgt_reg;
        flush_next    = 1'b0;
        redirect_next = 1'b0;
        pc_next       = 32'h0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    flush_next = 1'b1;
                    if (bus.if_busy) begin
                        tgt_next   = bus.branch_target;
                        state_next = DRAIN;
                    end else begin
                        redirect_next = 1'b1;
                        pc_next       = bus.branch_target;
                    end
                end
            end
            DRAIN: begin
                // The fetch landing now is stale: flush it as the PC is redirected.
                if (!bus.if_busy) begin
                    flush_next    = 1'b1;
                    redirect_next = 1'b1;
                    pc_next       = tgt_reg;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            tgt_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
        end
    end

    assign bus.stall       = rst ? '0    : stall_raw;
    assign bus.flush       = rst ? 1'b0  : flush_next;
    assign bus.pc_redirect = rst ? 1'b0  : redirect_next;
    assign bus.redirect_pc = rst ? 32'h0 : pc_next;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.stall[PC_STAGE]),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.flush),
        .cnt (bus.flush_cnt)
    );

    a_no_branch_in_drain: assert property (
        @(posedge clk) disable iff (rst) (state_reg == DRAIN) |-> !bus.branch_taken
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a queue-free behavioural model.
module tb_pipe_ctrl;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   model_on = 1'b0;

    // Model state: a redirect waiting for the fetch to drain, and the two counters.
    bit               m_pend = 1'b0;
    logic [31:0]      m_tgt  = 32'h0;
    logic [CNT_W-1:0] m_sc   = '0;
    logic [CNT_W-1:0] m_fc   = '0;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: stall depth from the deepest requesting stage; redirect now or after fetch drains.
    always @(negedge clk) begin
        if (model_on) begin
            int k;
            logic [5:0]  e_stall;
            logic        e_flush, e_redir;
            logic [31:0] e_pc;
            k = -1;
            if (bus_if.if_busy)   k = 1;
            if (bus_if.id_hazard) k = 2;
            if (bus_if.ex_busy)   k = 3;
            if (bus_if.mem_busy)  k = 4;
            e_stall = (k < 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
            e_flush = 1'b0;
            e_redir = 1'b0;
            e_pc    = 32'h0;
            if (rst) begin
                e_stall = 6'd0;
            end else if (m_pend) begin
                if (!bus_if.if_busy) begin
                    e_flush = 1'b1; e_redir = 1'b1; e_pc = m_tgt; m_pend = 1'b0;
                end
            end else if (bus_if.branch_taken && k < 3) begin
                e_flush = 1'b1;
                if (bus_if.if_busy) begin
                    m_pend = 1'b1; m_tgt = bus_if.branch_target;
                end else begin
                    e_redir = 1'b1; e_pc = bus_if.branch_target;
                end
            end
            check("stall",       32'(bus_if.stall),       32'(e_stall));
            check("flush",       32'(bus_if.flush),       32'(e_flush));
            check("pc_redirect", 32'(bus_if.pc_redirect), 32'(e_redir));
            check("redirect_pc", bus_if.redirect_pc,      e_pc);
            check("stall_cnt",   32'(bus_if.stall_cnt),   32'(m_sc));
            check("flush_cnt",   32'(bus_if.flush_cnt),   32'(m_fc));
            if (rst) begin
                m_pend = 1'b0; m_tgt = 32'h0; m_sc = '0; m_fc = '0;
            end else begin
                if (e_stall[0] && m_sc != CNT_MAX) m_sc = m_sc + 1'b1;
                if (e_flush && m_fc != CNT_MAX)    m_fc = m_fc + 1'b1;
            end
        end
    end

    task automatic drive(input logic r, input logic ib, input logic ih, input logic eb,
                         input logic mb, input logic bt, input logic [31:0] tg);
        @(posedge clk);
        #1;
        rst                  = r;
        bus_if.if_busy       = ib;
        bus_if.id_hazard     = ih;
        bus_if.ex_busy       = eb;
        bus_if.mem_busy      = mb;
        bus_if.branch_taken  = bt;
        bus_if.branch_target = tg;
        @(negedge clk);
        #1;
    endtask

    task automatic show(input string tag);
        $display("%-10s rst=%b req=%b%b%b%b bt=%b stall=%b flush=%b redir=%b pc=%h sc=%0d fc=%0d",
                 tag, rst, bus_if.mem_busy, bus_if.ex_busy, bus_if.id_hazard, bus_if.if_busy,
                 bus_if.branch_taken, bus_if.stall, bus_if.flush, bus_if.pc_redirect,
                 bus_if.redirect_pc, bus_if.stall_cnt, bus_if.flush_cnt);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.if_busy = 1'b0; bus_if.id_hazard = 1'b0; bus_if.ex_busy = 1'b0;
        bus_if.mem_busy = 1'b0; bus_if.branch_taken = 1'b0; bus_if.branch_target = 32'h0;
        @(posedge clk);
        #1;
        model_on = 1'b1;

        drive(1, 0, 0, 0, 0, 0, 0); show("reset");
        check("rst_stall", 32'(bus_if.stall), 32'h0);
        check("rst_cnt", 32'(bus_if.stall_cnt), 32'h0);

        // Mem and ID busy together: everything up to MEM stops.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 1, 0, 0); show("t1");
            check("t1_stall", 32'(bus_if.stall), 32'h1f);
            check("t1_flush", 32'(bus_if.flush), 32'h0);
        end
        drive(0, 0, 1, 0, 0, 0, 0); show("t2");
        check("t1_stall_cnt", 32'(bus_if.stall_cnt), 32'd3);
        check("t2_stall", 32'(bus_if.stall), 32'h07);
        drive(0, 0, 0, 0, 0, 0, 0); show("t2_idle");
        check("t2_clear", 32'(bus_if.stall), 32'h0);

        drive(0, 0, 0, 0, 0, 1, 32'h100); show("t3");
        check("t3_flush", 32'(bus_if.flush), 32'h1);
        check("t3_redir", 32'(bus_if.pc_redirect), 32'h1);
        check("t3_pc", bus_if.redirect_pc, 32'h100);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t3_flush_cnt", 32'(bus_if.flush_cnt), 32'd1);

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 32'h200); show("t4_c0");
        check("t4_c0_flush", 32'(bus_if.flush), 32'h1);
        check("t4_c0_redir", 32'(bus_if.pc_redirect), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0); show("t4_drain");
            check("t4_drain_flush", 32'(bus_if.flush), 32'h0);
            check("t4_drain_stall", 32'(bus_if.stall), 32'h03);
        end
        drive(0, 0, 0, 0, 0, 0, 0); show("t4_fall");
        check("t4_flush", 32'(bus_if.flush), 32'h1);
        check("t4_redir", 32'(bus_if.pc_redirect), 32'h1);
        check("t4_pc", bus_if.redirect_pc, 32'h200);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t4_flush_cnt", 32'(bus_if.flush_cnt), 32'd2);

        drive(0, 0, 0, 1, 0, 1, 32'h500); show("t5_held");
        check("t5_stall", 32'(bus_if.stall), 32'h0f);
        check("t5_noflush", 32'(bus_if.flush), 32'h0);
        check("t5_noredir", 32'(bus_if.pc_redirect), 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'h500); show("t5_go");
        check("t5_flush", 32'(bus_if.flush), 32'h1);
        check("t5_pc", bus_if.redirect_pc, 32'h500);

        drive(0, 1, 0, 0, 0, 1, 32'h300); show("t6_br");
        drive(1, 1, 0, 0, 0, 0, 0); show("t6_rst");
        check("t6_rst_flush", 32'(bus_if.flush), 32'h0);
        check("t6_rst_stall", 32'(bus_if.stall), 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0); show("t6_after");
        check("t6_fcnt", 32'(bus_if.flush_cnt), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0); show("t6_fall");
        check("t6_noredir", 32'(bus_if.pc_redirect), 32'h0);
        check("t6_noflush", 32'(bus_if.flush), 32'h0);

        for (int i = 0; i < 260; i++) drive(0, 0, 0, 0, 1, 0, 0);
        show("sat");
        check("sat_stall_cnt", 32'(bus_if.stall_cnt), 32'(CNT_MAX));
        drive(0, 0, 0, 0, 1, 0, 0);
        check("sat_hold", 32'(bus_if.stall_cnt), 32'(CNT_MAX));

        for (int i = 0; i < 4000; i++) begin
            logic bt;
            bt = !m_pend && ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 1), bt, $urandom());
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
